// File: rtl/adder_bist_pkg.sv
// Shared types, sizes and the golden full-adder function for the adder BIST.
package adder_bist_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ERR_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {cout, sum} for a one-bit full adder.
    function automatic logic [1:0] golden_add(input logic a, input logic b, input logic cin);
        logic sum;
        logic cout;
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
        return {cout, sum};
    endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Stimulus/response bus between the BIST engine (master) and the adder under test (slave).
interface adder_bist_if;

    logic a_o;
    logic b_o;
    logic cin_o;
    logic sum_i;
    logic cout_i;

    modport master (
        output a_o,
        output b_o,
        output cin_o,
        input  sum_i,
        input  cout_i
    );

    modport slave (
        input  a_o,
        input  b_o,
        input  cin_o,
        output sum_i,
        output cout_i
    );

endinterface

// File: rtl/adder_bist_golden.sv
// Combinational reference full adder that the BIST compares the target against.
module adder_golden
    import adder_bist_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        {cout, sum} = golden_add(a, b, cin);
    end

endmodule

// File: rtl/adder_bist.sv
// Exhaustive 8-vector BIST for a one-bit full adder: drives each vector for
// SETTLE+1 cycles, samples the response at the end of the window and logs failures.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; operands and results hold
// RUN     | sweeping vectors 0..7, sampling on the last edge of each window
// DONE    | single cycle: done pulse, pass reflects the completed run
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    adder_bist_if.master        tgt,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [NUM_VEC-1:0]  fail_mask
);

    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE);
    localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   mask_q, mask_d;
    logic                 pass_q, pass_d;

    logic gold_sum;
    logic gold_cout;
    logic sample_tc;
    logic last_vec;
    logic mismatch;
    logic accept;

    adder_golden u_golden (
        .a    (vec_q[2]),
        .b    (vec_q[1]),
        .cin  (vec_q[0]),
        .sum  (gold_sum),
        .cout (gold_cout)
    );

    assign sample_tc = (cnt_q == SETTLE_TC);
    assign last_vec  = (vec_q == LAST_VEC);
    assign mismatch  = (tgt.sum_i != gold_sum) || (tgt.cout_i != gold_cout);
    // start together with abort is treated as no request
    assign accept    = start && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                      state_d = ST_IDLE;
                else if (sample_tc && last_vec) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Abort suppresses every RUN update, so a coinciding sample is dropped.
    always_comb begin
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        mask_d = mask_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    vec_d  = '0;
                    cnt_d  = '0;
                    err_d  = '0;
                    mask_d = '0;
                    pass_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!abort) begin
                    if (sample_tc) begin
                        cnt_d = '0;
                        if (mismatch) begin
                            mask_d[vec_q] = 1'b1;
                            err_d         = err_q + ERR_W'(1);
                        end
                        if (last_vec) pass_d = (err_d == '0);
                        else          vec_d  = vec_q + VEC_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign tgt.a_o   = vec_q[2];
    assign tgt.b_o   = vec_q[1];
    assign tgt.cin_o = vec_q[0];
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter SETTLE, default 1, cycles of DUT settle time added to each vector window; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 abort  input  1  cancel a run in progress; returns to IDLE, no done pulse.
REQ-006 a_o  output  1  adder operand a driven to the DUT.
REQ-007 b_o  output  1  adder operand b driven to the DUT.
REQ-008 cin_o  output  1  adder carry-in driven to the DUT.
REQ-009 sum_i  input  1  DUT sum response.
REQ-010 cout_i  input  1  DUT carry-out response.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 pass  output  1  high when the last completed run had zero mismatches.
REQ-014 err_count  output  4  number of failing vectors in the last run, 0..8.
REQ-015 fail_mask  output  8  bit v set when vector v failed in the last run.

Function
REQ-016 Vector index v runs 0..7 in ascending order; {a_o,b_o,cin_o} = v (a_o is MSB).
REQ-017 Golden response: sum = a^b^cin; cout = majority(a,b,cin).
REQ-018 States: IDLE, RUN, DONE.
REQ-019 IDLE: start=1 -> RUN, v=0, settle counter=0, err_count/fail_mask/pass cleared on the same edge.
REQ-020 RUN: each vector held for exactly SETTLE+1 cycles; sum_i/cout_i sampled on the final edge of the window, the same edge that advances v.
REQ-021 Mismatch on either bit -> fail_mask[v]=1, err_count+1 on the sampling edge.
REQ-022 After vector 7 is sampled -> DONE; total RUN length = 8*(SETTLE+1) cycles.
REQ-023 DONE lasts exactly one cycle: done=1, busy=0, pass=(err_count==0); then IDLE.
REQ-024 busy=1 in RUN only; start ignored while in RUN or DONE.
REQ-025 abort=1 in RUN -> IDLE next edge; done stays 0; pass=0; err_count/fail_mask keep partial values.
REQ-026 abort and sampling edge coincide -> abort wins; that sample is discarded.
REQ-027 abort in IDLE or DONE has no effect; start and abort together in IDLE -> stays IDLE.
REQ-028 In IDLE and DONE, a_o/b_o/cin_o hold the last driven vector; 0 after reset.
REQ-029 pass, err_count, fail_mask hold until the next accepted start or reset.

Reset
REQ-030 rst=1 -> IDLE regardless of state, including mid-run; busy=0, done=0, pass=0, err_count=0, fail_mask=0, a_o=b_o=cin_o=0.
REQ-031 rst has priority over start and abort.

Structure
REQ-032 Package adder_bist_pkg holds the state enum, VEC_W=3, NUM_VEC=8 and the golden sum/cout function.
REQ-033 One sub-module, adder_golden: combinational reference full adder used for comparison.

Verification
REQ-034 Correct full adder as DUT, SETTLE=1, pulse start -> done 16 cycles after start accepted, pass=1, err_count=0, fail_mask=0x00.
REQ-035 DUT cout stuck at 0 -> err_count=4, fail_mask=0xE8, pass=0.
REQ-036 DUT sum stuck at 1 -> err_count=4, fail_mask=0x69; sum inverted -> err_count=8, fail_mask=0xFF.
REQ-037 SETTLE=3, abort asserted on cycle 10 of RUN -> IDLE next edge, no done pulse, pass=0, busy=0.
REQ-038 start re-pulsed during RUN -> ignored, done timing unchanged; rst at cycle 5 of RUN -> all outputs at reset values next cycle.
